mm_operand_streamer: RTL and testbench
======================================

Name: mm_operand_streamer

Overview:
- Host-side companion to matrix_multiplier. Buffers two 3x3 byte operand matrices written by a host.
- On command, streams the 18 bytes into the multiplier's byte-serial input under `start`.
- Then waits for `done` and captures the 9 serially presented 16-bit results into a readable result buffer.
- Sits between host/control logic and one matrix_multiplier instance.

Parameters:
- DATA_W, 8, operand byte width; matches multiplier `in`.
- RES_W, 16, result width; matches multiplier `o`.
- TIMEOUT_CYCLES, 1024, max cycles in WAIT_DONE before abort; must be >= 1.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- ld_we  in  1  operand write strobe.
- ld_addr  in  5  operand index: 0-8 = A row-major, 9-17 = B row-major.
- ld_data  in  DATA_W  operand byte.
- go  in  1  start-transfer pulse.
- busy  out  1  high from the cycle after an accepted go until return to IDLE.
- mm_start  out  1  drives multiplier `start`.
- mm_in  out  DATA_W  drives multiplier `in`.
- mm_o  in  RES_W  from multiplier `o`.
- mm_done  in  1  from multiplier `done`.
- rd_addr  in  4  result index 0-8, row-major C.
- rd_data  out  RES_W  combinational result[rd_addr]; 0 when rd_addr >= 9.
- res_valid  out  1  result buffer holds a complete fresh result set.
- timeout_err  out  1  last transfer aborted on timeout.

Behaviour:
- Single clock domain. All state changes on the rising edge of clk.
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - mm_start, busy, res_valid and timeout_err go to 0; mm_in goes to 0.
  - Counters, the 18-byte operand buffer and the 9-word result buffer are cleared to 0.
- Reset mid-operation aborts immediately: mm_start is low from the next edge. No partial results are flagged valid.
- Operand writes:
  - Accepted only in IDLE with go low.
  - ld_addr >= 18 is ignored.
  - ld_we while busy is ignored.
  - ld_we in the same cycle as go is ignored; go is still honoured.
- States: IDLE, STREAM, WAIT_DONE, CAPTURE.
- IDLE:
  - go=1 means next state STREAM.
  - On that edge: busy=1, res_valid=0, timeout_err=0, mm_start=1, mm_in=buf[0], stream counter=0.
  - go outside IDLE is ignored.
- STREAM:
  - mm_start stays high for exactly 18 consecutive cycles.
  - In the k-th of those cycles (k=0..17), mm_in=buf[k]: A bytes first, then B bytes.
  - On the edge ending cycle 17: mm_start=0, mm_in=0, go to WAIT_DONE with the wait counter cleared.
  - mm_done high during STREAM is ignored.
- WAIT_DONE:
  - The wait counter increments each cycle.
  - mm_done sampled high: result[0] <= mm_o on that edge, capture index=1, go to CAPTURE.
  - Counter reaches TIMEOUT_CYCLES with no done: go to IDLE, busy=0, timeout_err=1, res_valid stays 0.
- CAPTURE:
  - On each of the next 8 edges, result[idx] <= mm_o, regardless of mm_done level.
  - After result[8] is captured: go to IDLE, busy=0, res_valid=1.
  - mm_done staying high or re-asserting after capture is ignored until the next STREAM.
- Result buffer is written only in WAIT_DONE (index 0) and CAPTURE. A new go clears res_valid but leaves the old contents in place until they are overwritten.
- Cycle counts:
  - go to first mm_start: 1 edge.
  - mm_start high: 18 cycles.
  - Done to res_valid: 9 edges.
- No arithmetic is performed; widths pass straight through.

Test Plan:
- Load A=01..09 and B=09,08,...,01, pulse go.
  - Required: mm_start high exactly 18 cycles carrying 01..09 then 09..01, starting 1 cycle after go.
  - A behavioural multiplier model asserts done and presents 30,24,18,84,69,54,138,114,90.
  - Required: res_valid=1 nine edges after done; rd_addr 0..8 return those values; busy=0.
- TIMEOUT_CYCLES=16, model never asserts done.
  - Required: busy drops and timeout_err=1 exactly 16 cycles after mm_start falls; res_valid=0.
  - A following go clears timeout_err.
- Pulse go and ld_we(addr 0, 0xAA) mid-STREAM.
  - Required: the stream is unchanged and buf[0] is unchanged; a second run re-streams the original byte 0.
- Assert reset at stream cycle 5.
  - Required: the next edge gives mm_start=0, mm_in=0, busy=0, res_valid=0.
  - After reload and go, a full 18-byte stream is produced.
- Boundary cases:
  - ld_addr=20 write is ignored.
  - rd_addr=12 returns 0.
  - A 1-cycle done glitch during STREAM is ignored.
  - done held high 20 cycles still captures exactly 9 words.

Source files
------------

// File: rtl/mm_operand_streamer.sv
// ---------------------------------------------------------------------------
// mm_operand_streamer
//
// Host-side companion to a byte-serial 3x3 matrix multiplier.
// - The host loads two 3x3 operand matrices into an 18-byte buffer:
//   A occupies entries 0-8 and B occupies entries 9-17, both row-major.
// - A go pulse streams the 18 bytes to the multiplier while mm_start is held
//   high.
// - The block then waits for mm_done and captures the nine serial 16-bit
//   results into a result buffer that the host can read.
// - If done never arrives within TIMEOUT_CYCLES, the transfer is abandoned
//   and timeout_err is raised.
//
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   ld_we        operand write strobe (honoured only when idle and go low)
//   ld_addr      operand index 0-17; higher indices are dropped
//   ld_data      operand byte
//   go           start-transfer pulse (only honoured when idle)
//   busy         high from the cycle after an accepted go until back in idle
//   mm_start     multiplier start / byte-valid
//   mm_in        multiplier byte input
//   mm_o         multiplier serial result word
//   mm_done      multiplier done, marks the first result word
//   rd_addr      result index 0-8, row-major C
//   rd_data      result[rd_addr] (combinational), 0 for out-of-range index
//   res_valid    result buffer holds a complete, fresh result set
//   timeout_err  the last transfer was aborted on timeout
// ---------------------------------------------------------------------------
module mm_operand_streamer #(
  parameter int DATA_W         = 8,
  parameter int RES_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic [4:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              go,
  output logic              busy,
  output logic              mm_start,
  output logic [DATA_W-1:0] mm_in,
  input  logic [RES_W-1:0]  mm_o,
  input  logic              mm_done,
  input  logic [3:0]        rd_addr,
  output logic [RES_W-1:0]  rd_data,
  output logic              res_valid,
  output logic              timeout_err
);

  localparam int NUM_OPS = 18;
  localparam int NUM_RES = 9;
  // The wait counter only needs to reach TIMEOUT_CYCLES-1; the abort happens
  // on the edge that would take it to TIMEOUT_CYCLES.
  localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2,
    CAPTURE   = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] opbuf [NUM_OPS];
  logic [RES_W-1:0]  res   [NUM_RES];

  logic [4:0]        scnt;   // index of the byte currently on mm_in
  logic [WCNT_W-1:0] wcnt;   // cycles spent waiting for done
  logic [3:0]        cidx;   // next result slot to fill

  logic stream_last;
  logic wait_expired;
  logic capture_last;
  logic op_wr;

  assign stream_last  = (scnt == 5'd17);
  assign wait_expired = (wcnt == WAIT_LAST);
  assign capture_last = (cidx == 4'd8);

  // A write that coincides with go is dropped so the snapshot being streamed
  // is exactly what the host had loaded before asking for the transfer.
  assign op_wr = ld_we && !go && (state == IDLE) && (ld_addr < 5'd18);

  assign rd_data = (rd_addr < 4'd9) ? res[rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (go) begin
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        if (stream_last) begin
          state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // done takes priority over an expiring timer on the same edge
        if (mm_done) begin
          state_nxt = CAPTURE;
        end else if (wait_expired) begin
          state_nxt = IDLE;
        end
      end
      CAPTURE: begin
        if (capture_last) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= 1'b0;
      mm_start    <= 1'b0;
      mm_in       <= '0;
      res_valid   <= 1'b0;
      timeout_err <= 1'b0;
      scnt        <= '0;
      wcnt        <= '0;
      cidx        <= '0;
      for (int i = 0; i < NUM_OPS; i++) begin
        opbuf[i] <= '0;
      end
      for (int i = 0; i < NUM_RES; i++) begin
        res[i] <= '0;
      end
    end else begin
      if (op_wr) begin
        opbuf[ld_addr] <= ld_data;
      end

      case (state)
        IDLE: begin
          if (go) begin
            busy        <= 1'b1;
            res_valid   <= 1'b0;
            timeout_err <= 1'b0;
            mm_start    <= 1'b1;
            mm_in       <= opbuf[0];
            scnt        <= '0;
          end
        end

        STREAM: begin
          // mm_in is registered one byte ahead so byte k is on the wire
          // during the k-th cycle of mm_start.
          if (stream_last) begin
            mm_start <= 1'b0;
            mm_in    <= '0;
            wcnt     <= '0;
          end else begin
            scnt  <= scnt + 5'd1;
            mm_in <= opbuf[scnt + 5'd1];
          end
        end

        WAIT_DONE: begin
          if (mm_done) begin
            res[0] <= mm_o;
            cidx   <= 4'd1;
          end else if (wait_expired) begin
            busy        <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
        end

        CAPTURE: begin
          // Words 1-8 follow done back to back; done's level is irrelevant.
          res[cidx] <= mm_o;
          cidx      <= cidx + 4'd1;
          if (capture_last) begin
            busy      <= 1'b0;
            res_valid <= 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_operand_streamer.sv
module tb_mm_operand_streamer;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int TOUT   = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_we;
  logic [4:0]        ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              go;
  logic              busy;
  logic              mm_start;
  logic [DATA_W-1:0] mm_in;
  logic [RES_W-1:0]  mm_o;
  logic              mm_done;
  logic [3:0]        rd_addr;
  logic [RES_W-1:0]  rd_data;
  logic              res_valid;
  logic              timeout_err;

  always #5 clk = ~clk;

  mm_operand_streamer #(
    .DATA_W(DATA_W),
    .RES_W(RES_W),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ld_we(ld_we),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .go(go),
    .busy(busy),
    .mm_start(mm_start),
    .mm_in(mm_in),
    .mm_o(mm_o),
    .mm_done(mm_done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .res_valid(res_valid),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: what the host has loaded and what the buffer must hold.
  logic [7:0]  model_buf [18];
  logic [15:0] model_res [9];
  logic        model_valid;
  logic        model_terr;
  logic [7:0]  exp_q [$];

  bit mon_on  = 0;
  bit rd_chk  = 0;
  bit aborted = 0;
  int run_len = 0;

  int lit [9] = '{30, 24, 18, 84, 69, 54, 138, 114, 90};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_addr = 4'($urandom_range(0, 15));
  endtask

  task automatic rd_read(input logic [3:0] a, input logic [15:0] exp);
    rd_addr = a;
    #1;
    check("rd_literal", rd_data, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 18; i++) model_buf[i] = '0;
    for (int i = 0; i < 9; i++) model_res[i] = '0;
    model_valid = 1'b0;
    model_terr  = 1'b0;
  endtask

  task automatic ld_write(input logic [4:0] a, input logic [7:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
    if (a < 5'd18) model_buf[a] = d;
  endtask

  // Compare process: stream contents/length every cycle, plus idle-state
  // outputs and result readback whenever no transfer is in flight.
  always @(negedge clk) begin
    logic [15:0] e;
    if (mon_on) begin
      if (mm_start) begin
        run_len++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got byte %0h, expected no stream", mm_in);
        end else begin
          check("stream_byte", mm_in, exp_q.pop_front());
        end
      end else begin
        check("idle_mm_in", mm_in, 0);
        if (run_len != 0) begin
          if (!aborted) check("stream_len", run_len, 18);
          run_len = 0;
        end
      end
      if (rd_chk && !reset) begin
        e = (rd_addr < 4'd9) ? model_res[rd_addr] : 16'h0;
        check("rd_data", rd_data, e);
        check("idle_busy", busy, 0);
        check("res_valid", res_valid, model_valid);
        check("timeout_err", timeout_err, model_terr);
      end
    end
  end

  task automatic start_run(input bit with_we);
    aborted = 0;
    rd_chk  = 0;
    for (int i = 0; i < 18; i++) exp_q.push_back(model_buf[i]);
    go = 1'b1;
    if (with_we) begin
      ld_we = 1'b1; ld_addr = 5'($urandom_range(0, 17)); ld_data = 8'($urandom);
    end
    tick();
    go = 1'b0; ld_we = 1'b0;
    check("go_busy", busy, 1);
    check("go_start", mm_start, 1);
    check("go_terr", timeout_err, 0);
    check("go_valid", res_valid, 0);
  endtask

  task automatic stream_rest(input int glitch_k, input bit midgo);
    int n = 0;
    while (mm_start && n < 40) begin
      if (n == glitch_k) begin mm_done = 1'b1; mm_o = 16'($urandom); end
      if (midgo && n == 3) begin
        go = 1'b1; ld_we = 1'b1; ld_addr = 5'd0; ld_data = 8'hAA;
      end
      tick();
      mm_done = 1'b0; go = 1'b0; ld_we = 1'b0;
      n++;
    end
    check("stream_cycles", n, 18);
    check("wait_busy", busy, 1);
  endtask

  task automatic finish_run(input int dly, input int hold);
    logic [15:0] c [9];
    int s;
    for (int r = 0; r < 3; r++)
      for (int cc = 0; cc < 3; cc++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(model_buf[r*3+k]) * int'(model_buf[9+k*3+cc]);
        c[r*3+cc] = s[15:0];
      end
    for (int i = 0; i < dly; i++) begin
      if (i == 0) begin
        ld_we = 1'b1; ld_addr = 5'($urandom_range(0, 17)); ld_data = 8'($urandom);
      end
      tick();
      ld_we = 1'b0;
    end
    for (int i = 0; i < 9; i++) begin
      mm_done = (i == 0 || i < hold) ? 1'b1 : 1'($urandom_range(0, 1));
      mm_o    = c[i];
      tick();
      if (i == 7) begin
        check("cap_valid_early", res_valid, 0);
        check("cap_busy", busy, 1);
      end
    end
    check("done_valid", res_valid, 1);
    check("done_busy", busy, 0);
    check("done_terr", timeout_err, 0);
    model_res   = c;
    model_valid = 1'b1;
    model_terr  = 1'b0;
    rd_chk      = 1;
    for (int i = 9; i < hold; i++) begin
      mm_done = 1'b1; mm_o = 16'($urandom);
      tick();
    end
    mm_done = 1'b0;
    mm_o    = 16'($urandom);
  endtask

  task automatic timeout_run();
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, TOUT);
    check("timeout_flag", timeout_err, 1);
    check("timeout_valid", res_valid, 0);
    model_terr  = 1'b1;
    model_valid = 1'b0;
    rd_chk      = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_data = '0; go = 1'b0;
    mm_done = 1'b0; mm_o = '0; rd_addr = '0;
    model_clear();
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_start", mm_start, 0);
    check("rst_mm_in", mm_in, 0);
    check("rst_valid", res_valid, 0);
    check("rst_terr", timeout_err, 0);
    reset = 1'b0;
    tick();
    mon_on = 1;
    rd_chk = 1;
    rd_read(4'd0, 16'h0);
    rd_read(4'd8, 16'h0);

    // Directed: A = 1..9, B = 9..1, with an ignored out-of-range write and
    // a done glitch during the stream.
    for (int i = 0; i < 9; i++) ld_write(5'(i), 8'(i + 1));
    for (int i = 0; i < 9; i++) ld_write(5'(9 + i), 8'(9 - i));
    ld_write(5'd20, 8'h55);
    start_run(0);
    stream_rest(7, 0);
    finish_run(3, 1);
    for (int i = 0; i < 9; i++) rd_read(4'(i), 16'(lit[i]));
    rd_read(4'd12, 16'h0);

    // Timeout with the multiplier silent; old results stay readable.
    start_run(0);
    stream_rest(-1, 0);
    timeout_run();
    rd_read(4'd0, 16'd30);

    // go + write mid-stream are ignored; done held 20 cycles.
    start_run(0);
    stream_rest(-1, 1);
    finish_run(0, 20);
    start_run(1);
    stream_rest(-1, 0);
    finish_run(5, 1);

    // Reset at stream cycle 5.
    start_run(0);
    repeat (5) tick();
    reset = 1'b1;
    aborted = 1;
    tick();
    check("rr_start", mm_start, 0);
    check("rr_mm_in", mm_in, 0);
    check("rr_busy", busy, 0);
    check("rr_valid", res_valid, 0);
    check("rr_terr", timeout_err, 0);
    reset = 1'b0;
    exp_q.delete();
    model_clear();
    rd_chk = 1;
    tick();
    for (int i = 0; i < 18; i++) ld_write(5'(i), 8'($urandom));
    start_run(0);
    stream_rest(-1, 0);
    finish_run(2, 1);

    // Randomized transfers.
    for (int it = 0; it < 16; it++) begin
      int nw = $urandom_range(0, 6);
      for (int w = 0; w < nw; w++)
        ld_write(5'($urandom_range(0, 31)), 8'($urandom));
      start_run(1'($urandom_range(0, 1)));
      stream_rest(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : -1, 0);
      if (it % 5 == 4) timeout_run();
      else finish_run($urandom_range(0, 12), $urandom_range(1, 20));
      tick();
    end

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
